branch_resolve: RTL and testbench
=================================

# branch_resolve

Branch resolution unit for the pipeline CPU. It consumes the 32-bit compare result and the 3-bit compare code of a branch in the execute stage, and decides taken or not-taken under static not-taken prediction. For a taken branch it computes the target and issues a registered PC redirect with pipeline flushes, then squashes wrong-path branch requests for a configurable shadow window. It also keeps saturating branch and taken counters.

## Interface
- CNT_W, 16, width of the statistics counters
- SHADOW_CYCLES, 1, cycles after a redirect during which br_valid is squashed (1..7)

- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  pipeline hold; when high, no new branch is accepted and a pending redirect is held
- br_valid  input  1  execute stage holds a branch this cycle
- br_ctrl  input  3  compare code: 001 beq, 000 bne, 010 slt-type, 110 blez, 100 bltz, 111 bgtz; 011 and 101 are illegal
- br_result  input  32  compare result; only bit 0 is used, bits 31:1 are ignored
- br_pc_plus4  input  32  PC+4 of the branch
- br_imm  input  32  sign-extended word offset
- redirect  output  1  PC mux select to redirect_pc
- redirect_pc  output  32  branch target
- flush_if_id  output  1  squash the IF/ID register
- flush_id_ex  output  1  squash the ID/EX register
- busy  output  1  high whenever the state is not IDLE
- branch_count  output  CNT_W  branches accepted
- taken_count  output  CNT_W  branches resolved taken

## Operation
- States: IDLE, REDIRECT, SHADOW.
- Accept: a branch is accepted when state=IDLE, stall=0 and br_valid=1.
- Taken decision: taken = br_result[0] when br_ctrl is a legal code; an illegal code (011, 101) is always not-taken.
- Target: br_pc_plus4 + (br_imm << 2), taken modulo 2^32 so that overflow wraps. It is registered into redirect_pc on accept.
- IDLE:
  - Accept and taken: go to REDIRECT.
  - Accept and not-taken: stay in IDLE, no outputs asserted.
- REDIRECT:
  - redirect, flush_if_id and flush_id_ex are high.
  - If stall=1: stay in REDIRECT with outputs and redirect_pc held.
  - If stall=0: go to SHADOW and load the shadow counter with SHADOW_CYCLES-1.
- SHADOW:
  - br_valid is ignored: no accept, no counting.
  - The shadow counter decrements only when stall=0.
  - Go to IDLE when stall=0 and the counter is 0.
  - Outputs redirect and flush_* are low.
- Counters:
  - branch_count increments on every accept.
  - taken_count increments on every accept that is taken.
  - Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset values: state IDLE; redirect, flush_if_id, flush_id_ex and busy = 0; redirect_pc = 0; both counters = 0.
- Latency: an accept in cycle N gives redirect = 1 in cycle N+1, registered with no combinational path from inputs.
- The redirect pulse lasts exactly 1 cycle if stall=0 in N+1; otherwise it stays high until the first cycle with stall=0, inclusive.
- With stall=0 throughout, the first new accept can happen at cycle N+2+SHADOW_CYCLES.
- A not-taken accept in cycle N allows another accept in cycle N+1, i.e. back-to-back not-taken branches are supported.
- stall=1 in IDLE blocks the accept; the branch is sampled later, once stall falls, if br_valid is still high.
- Reset asserted in any state wins in that edge: all state, outputs and counters clear, and the pending redirect is dropped.
- The counters update at the same edge as the accept.

## Test plan
- beq taken: br_ctrl=001, br_result=1, pc_plus4=0x0000_1000, imm=0x0000_0004 -> redirect and both flushes high for one cycle at N+1, redirect_pc=0x0000_1010, branch_count=1, taken_count=1.
- Backward wrap and negative offset: pc_plus4=0x0000_0004, imm=0xFFFF_FFFE, br_result=1 -> redirect_pc=0xFFFF_FFFC. Also bne with br_result=0 -> no redirect, branch_count increments, taken_count unchanged.
- Illegal code and ignored upper bits: br_ctrl=011 with br_result=0xFFFF_FFFF -> not-taken. br_ctrl=111 with br_result=0xFFFF_FFFE -> not-taken, because only bit 0 is used.
- Stall during REDIRECT: stall=1 for 3 cycles after the accept -> redirect held high for 4 cycles with redirect_pc constant. With SHADOW_CYCLES=2, br_valid=1 held for 2 more cycles -> no accept and no count change.
- Saturation and reset: with CNT_W=4, 20 taken branches -> both counters equal 15. Reset asserted while in REDIRECT -> next cycle redirect=0, busy=0, counters=0.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution under static not-taken prediction.
// Registered redirect/flush, shadow squash window, saturating stats.
module branch_resolve #(
  parameter int CNT_W         = 16,
  parameter int SHADOW_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [2:0]       br_ctrl,
  input  logic [31:0]      br_result,
  input  logic [31:0]      br_pc_plus4,
  input  logic [31:0]      br_imm,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDIRECT,
    S_SHADOW
  } state_t;

  localparam logic [2:0] SH_LOAD =
    3'(SHADOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX =
    {CNT_W{1'b1}};

  state_t           r_state;
  logic [2:0]       r_shadow;
  logic             r_redirect;
  logic             r_flush_if_id;
  logic             r_flush_id_ex;
  logic             r_busy;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_taken_count;

  logic        w_legal;
  logic        w_taken;
  logic        w_accept;
  logic [31:0] w_target;
  logic        w_unused_bits;

  // Only bit 0 of the compare result and the low 30 imm bits matter.
  assign w_unused_bits =
    ^{br_result[31:1], br_imm[31:30]};

  // Codes 011 and 101 have no defined compare and resolve not-taken.
  always_comb begin
    w_legal = 1'b1;
    unique case (br_ctrl)
      3'b011,
      3'b101:  w_legal = 1'b0;
      default: w_legal = 1'b1;
    endcase
  end

  assign w_taken  = w_legal & br_result[0];
  assign w_accept = (r_state == S_IDLE)
                  & ~stall & br_valid;
  assign w_target = br_pc_plus4
                  + {br_imm[29:0], 2'b00};

  // Resolution FSM: redirect held through stalls, then a shadow window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_shadow      <= '0;
      r_redirect    <= 1'b0;
      r_flush_if_id <= 1'b0;
      r_flush_id_ex <= 1'b0;
      r_busy        <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_redirect_pc <= w_target;
            if (w_taken) begin
              r_state       <= S_REDIRECT;
              r_redirect    <= 1'b1;
              r_flush_if_id <= 1'b1;
              r_flush_id_ex <= 1'b1;
              r_busy        <= 1'b1;
            end
          end
        end
        S_REDIRECT: begin
          if (!stall) begin
            r_state       <= S_SHADOW;
            r_shadow      <= SH_LOAD;
            r_redirect    <= 1'b0;
            r_flush_if_id <= 1'b0;
            r_flush_id_ex <= 1'b0;
          end
        end
        S_SHADOW: begin
          if (!stall) begin
            if (r_shadow == 3'd0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_shadow <= r_shadow - 3'd1;
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_redirect    <= 1'b0;
          r_flush_if_id <= 1'b0;
          r_flush_id_ex <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics, updated on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_count <= '0;
      r_taken_count  <= '0;
    end else if (w_accept) begin
      if (r_branch_count != CNT_MAX)
        r_branch_count <= r_branch_count + CNT_ONE;
      if (w_taken && r_taken_count != CNT_MAX)
        r_taken_count <= r_taken_count + CNT_ONE;
    end
  end

  assign redirect     = r_redirect;
  assign redirect_pc  = r_redirect_pc;
  assign flush_if_id  = r_flush_if_id;
  assign flush_id_ex  = r_flush_id_ex;
  assign busy         = r_busy;
  assign branch_count = r_branch_count;
  assign taken_count  = r_taken_count;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed steps then random traffic
// compared each cycle against a cycle-count reference model.
module tb_branch_resolve;

  localparam int CNT_W = 4;
  localparam int SH    = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             stall;
  logic             br_valid;
  logic [2:0]       br_ctrl;
  logic [31:0]      br_result;
  logic [31:0]      br_pc_plus4;
  logic [31:0]      br_imm;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             busy;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  int checks;
  int failures;

  // reference model
  bit          m_redir;
  int          m_shadow_left;
  logic [31:0] m_pc;
  int          m_bc;
  int          m_tc;

  branch_resolve #(
    .CNT_W(CNT_W),
    .SHADOW_CYCLES(SH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .br_valid(br_valid),
    .br_ctrl(br_ctrl),
    .br_result(br_result),
    .br_pc_plus4(br_pc_plus4),
    .br_imm(br_imm),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex),
    .busy(busy),
    .branch_count(branch_count),
    .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit v,
                       input logic [2:0] c,
                       input logic [31:0] r,
                       input logic [31:0] p,
                       input logic [31:0] im,
                       input bit st);
    bit tk;
    if (rst) begin
      m_redir = 0;
      m_shadow_left = 0;
      m_pc = 0;
      m_bc = 0;
      m_tc = 0;
    end else if (m_redir) begin
      if (!st) begin
        m_redir = 0;
        m_shadow_left = SH;
      end
    end else if (m_shadow_left > 0) begin
      if (!st) m_shadow_left--;
    end else if (v && !st) begin
      tk = !(c == 3 || c == 5) && r[0];
      m_pc = p + im * 32'd4;
      if (m_bc < CMAX) m_bc++;
      if (tk) begin
        if (m_tc < CMAX) m_tc++;
        m_redir = 1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit v,
                      input logic [2:0] c,
                      input logic [31:0] r,
                      input logic [31:0] p,
                      input logic [31:0] im,
                      input bit st);
    reset       = rst;
    br_valid    = v;
    br_ctrl     = c;
    br_result   = r;
    br_pc_plus4 = p;
    br_imm      = im;
    stall       = st;
    @(posedge clk);
    model(rst, v, c, r, p, im, st);
    #1;
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("flush_if_id", 32'(flush_if_id), 32'(m_redir));
    chk("flush_id_ex", 32'(flush_id_ex), 32'(m_redir));
    chk("busy", 32'(busy),
        32'(m_redir || m_shadow_left > 0));
    chk("redirect_pc", redirect_pc, m_pc);
    chk("branch_count", 32'(branch_count), 32'(m_bc));
    chk("taken_count", 32'(taken_count), 32'(m_tc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 3'b000, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_redir = 0;
    m_shadow_left = 0;
    m_pc = 0;
    m_bc = 0;
    m_tc = 0;

    // reset state
    step(1, 0, 3'b000, 0, 0, 0, 0);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_bc", 32'(branch_count), 0);

    // beq taken
    step(0, 1, 3'b001, 1, 32'h1000, 32'h4, 0);
    chk("beq_redirect", 32'(redirect), 1);
    chk("beq_flush", 32'(flush_id_ex), 1);
    chk("beq_pc", redirect_pc, 32'h1010);
    chk("beq_bc", 32'(branch_count), 1);
    chk("beq_tc", 32'(taken_count), 1);
    idle(1);
    chk("beq_pulse_end", 32'(redirect), 0);
    idle(3);
    chk("beq_idle", 32'(busy), 0);

    // backward wrap
    step(0, 1, 3'b001, 1, 32'h4, 32'hFFFF_FFFE, 0);
    chk("wrap_pc", redirect_pc, 32'hFFFF_FFFC);
    idle(4);

    // bne not taken
    step(0, 1, 3'b000, 0, 32'h20, 32'h8, 0);
    chk("bne_redirect", 32'(redirect), 0);
    chk("bne_bc", 32'(branch_count), 3);
    chk("bne_tc", 32'(taken_count), 2);

    // illegal code, upper bits ignored, back-to-back
    step(0, 1, 3'b011, 32'hFFFF_FFFF, 32'h40, 32'h1, 0);
    chk("illegal_redirect", 32'(redirect), 0);
    step(0, 1, 3'b111, 32'hFFFF_FFFE, 32'h80, 32'h1, 0);
    chk("bit0_redirect", 32'(redirect), 0);
    chk("b2b_bc", 32'(branch_count), 5);
    chk("b2b_tc", 32'(taken_count), 2);

    // stall during redirect
    step(0, 1, 3'b110, 1, 32'h100, 32'h10, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3'b001, 1, 32'h900, 32'h3, 1);
      chk("stall_redirect", 32'(redirect), 1);
      chk("stall_pc", redirect_pc, 32'h140);
    end
    step(0, 1, 3'b001, 1, 32'h900, 32'h3, 0);
    chk("stall_release", 32'(redirect), 0);
    step(0, 1, 3'b001, 1, 32'h900, 32'h3, 0);
    step(0, 1, 3'b001, 1, 32'h900, 32'h3, 0);
    chk("shadow_bc", 32'(branch_count), 6);
    chk("shadow_tc", 32'(taken_count), 3);
    chk("shadow_pc", redirect_pc, 32'h140);

    // saturation
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 3'b100, 1, 32'(i * 16), 32'h1, 0);
      idle(4);
    end
    chk("sat_bc", 32'(branch_count), 15);
    chk("sat_tc", 32'(taken_count), 15);

    // reset while in redirect
    step(0, 1, 3'b010, 1, 32'h500, 32'h2, 0);
    chk("pre_rst_redirect", 32'(redirect), 1);
    step(1, 0, 3'b000, 0, 0, 0, 0);
    chk("rst_mid_redirect", 32'(redirect), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_bc", 32'(branch_count), 0);
    chk("rst_mid_tc", 32'(taken_count), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 6),
           3'($urandom_range(0, 7)),
           $urandom(), $urandom(), $urandom(),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
